// File: rtl/signed_negcmp_pipe_if.sv
// signed_negcmp_pipe_if: valid/ready sample and result bus of the negate-compare pipe
interface signed_negcmp_pipe_if #(parameter int W = 2);
  logic in_valid, in_ready, in_exp, out_valid, out_ready, out_res, out_match;
  logic [W-1:0] in_a;
  modport master(output in_valid, in_a, in_exp, out_ready, input in_ready, out_valid, out_res, out_match);
  modport slave(input in_valid, in_a, in_exp, out_ready, output in_ready, out_valid, out_res, out_match);
endinterface

// File: rtl/signed_negcmp_pipe.sv
// signed_negcmp_pipe: two-stage valid/ready evaluator of signed (-a <= a) with match counters
module signed_negcmp_pipe #(
  parameter int W = 2,
  parameter int CW = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  signed_negcmp_pipe_if.slave bus,
  output logic [CW-1:0] pass_cnt,
  output logic [CW-1:0] fail_cnt,
  output logic err
);
  logic s1_valid_q, s1_valid_d, s1_exp_q, s1_exp_d;
  logic [W-1:0] s1_a_q, s1_a_d, s1_neg_q, s1_neg_d;
  logic s2_valid_q, s2_valid_d, s2_res_q, s2_res_d, s2_match_q, s2_match_d;
  logic [CW-1:0] pass_q, pass_d, fail_q, fail_d;
  logic err_q, err_d;
  logic s1_adv, s2_adv, in_acc, out_acc, s1_to_s2, res;
  always_comb begin
    s2_adv = !s2_valid_q || bus.out_ready;
    s1_adv = !s1_valid_q || s2_adv;
    in_acc = bus.in_valid && s1_adv;
    out_acc = s2_valid_q && bus.out_ready;
    s1_to_s2 = s1_valid_q && s2_adv;
    res = $signed(s1_neg_q) <= $signed(s1_a_q);
    s1_valid_d = in_acc || (s1_valid_q && !s2_adv);
    s1_a_d = in_acc ? bus.in_a : s1_a_q;
    s1_neg_d = in_acc ? ~bus.in_a + W'(1) : s1_neg_q;
    s1_exp_d = in_acc ? bus.in_exp : s1_exp_q;
    s2_valid_d = s2_adv ? s1_valid_q : s2_valid_q;
    s2_res_d = s1_to_s2 ? res : s2_res_q;
    s2_match_d = s1_to_s2 ? (res == s1_exp_q) : s2_match_q;
    pass_d = clr ? '0 : (out_acc && s2_match_q && !(&pass_q)) ? pass_q + CW'(1) : pass_q;
    fail_d = clr ? '0 : (out_acc && !s2_match_q && !(&fail_q)) ? fail_q + CW'(1) : fail_q;
    err_d = !clr && (err_q || (out_acc && !s2_match_q));
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_q <= 1'b0;
      s1_a_q <= '0;
      s1_neg_q <= '0;
      s1_exp_q <= 1'b0;
      s2_valid_q <= 1'b0;
      s2_res_q <= 1'b0;
      s2_match_q <= 1'b0;
      pass_q <= '0;
      fail_q <= '0;
      err_q <= 1'b0;
    end else begin
      s1_valid_q <= s1_valid_d;
      s1_a_q <= s1_a_d;
      s1_neg_q <= s1_neg_d;
      s1_exp_q <= s1_exp_d;
      s2_valid_q <= s2_valid_d;
      s2_res_q <= s2_res_d;
      s2_match_q <= s2_match_d;
      pass_q <= pass_d;
      fail_q <= fail_d;
      err_q <= err_d;
    end
  end
  assign bus.in_ready = s1_adv;
  assign bus.out_valid = s2_valid_q;
  assign bus.out_res = s2_res_q;
  assign bus.out_match = s2_match_q;
  assign pass_cnt = pass_q;
  assign fail_cnt = fail_q;
  assign err = err_q;
endmodule

// File: tb/tb_signed_negcmp_pipe.sv
// tb_signed_negcmp_pipe: randomized and directed scoreboard bench over W=1, W=2 and W=4 instances
module tb_signed_negcmp_pipe;
  localparam int WS[3] = '{1, 2, 4};
  localparam int CS[3] = '{3, 16, 5};
  typedef struct {
    int cyc;
    logic [2:0] res;
    logic [2:0] m;
  } ent_t;
  logic clk = 0, rst = 1, clr = 0, v = 0, rdy = 0;
  logic [3:0] a = '0;
  logic [2:0] ex = '0;
  logic [2:0] o_v, o_r, o_m, i_r, o_e;
  logic [2:0] p1, f1;
  logic [15:0] p2, f2;
  logic [4:0] p4, f4;
  logic [31:0] pcnt[3], fcnt[3];
  ent_t q[$];
  int cyc = 0, n_cmp = 0, n_bad = 0;
  int pc[3], fc[3];
  logic [2:0] er;
  always #5 clk = ~clk;
  signed_negcmp_pipe_if #(.W(1)) b1();
  signed_negcmp_pipe_if #(.W(2)) b2();
  signed_negcmp_pipe_if #(.W(4)) b4();
  assign b1.in_valid = v;
  assign b2.in_valid = v;
  assign b4.in_valid = v;
  assign b1.in_a = a[0:0];
  assign b2.in_a = a[1:0];
  assign b4.in_a = a;
  assign b1.in_exp = ex[0];
  assign b2.in_exp = ex[1];
  assign b4.in_exp = ex[2];
  assign b1.out_ready = rdy;
  assign b2.out_ready = rdy;
  assign b4.out_ready = rdy;
  assign o_v = {b4.out_valid, b2.out_valid, b1.out_valid};
  assign o_r = {b4.out_res, b2.out_res, b1.out_res};
  assign o_m = {b4.out_match, b2.out_match, b1.out_match};
  assign i_r = {b4.in_ready, b2.in_ready, b1.in_ready};
  assign pcnt[0] = 32'(p1);
  assign pcnt[1] = 32'(p2);
  assign pcnt[2] = 32'(p4);
  assign fcnt[0] = 32'(f1);
  assign fcnt[1] = 32'(f2);
  assign fcnt[2] = 32'(f4);
  signed_negcmp_pipe #(.W(1), .CW(3)) u1(.clk(clk), .rst(rst), .clr(clr), .bus(b1), .pass_cnt(p1), .fail_cnt(f1), .err(o_e[0]));
  signed_negcmp_pipe #(.W(2), .CW(16)) u2(.clk(clk), .rst(rst), .clr(clr), .bus(b2), .pass_cnt(p2), .fail_cnt(f2), .err(o_e[1]));
  signed_negcmp_pipe #(.W(4), .CW(5)) u4(.clk(clk), .rst(rst), .clr(clr), .bus(b4), .pass_cnt(p4), .fail_cnt(f4), .err(o_e[2]));

  function automatic logic ref_res(input int w, input logic [3:0] x);
    int val, neg;
    val = int'(x) & ((1 << w) - 1);
    if (val >= (1 << (w - 1))) val -= (1 << w);
    neg = -val;
    if (neg >= (1 << (w - 1))) neg -= (1 << w);
    return neg <= val;
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_cmp++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s: got %0d want %0d (cycle %0d)", tag, got, want, cyc);
    end
  endtask

  task automatic step(input logic iv, input logic [3:0] ia, input logic ir, input logic ic, input logic iw, input logic irst);
    ent_t e;
    logic [2:0] rr;
    logic acc;
    for (int d = 0; d < 3; d++) rr[d] = ref_res(WS[d], ia);
    v = iv;
    a = ia;
    rdy = ir;
    clr = ic;
    rst = irst;
    ex = rr ^ {3{iw}};
    #1;
    for (int d = 0; d < 3; d++) begin
      check($sformatf("in_ready_w%0d", WS[d]), 32'(i_r[d]), 32'(q.size() < 2 || ir));
      if (q.size() > 0 && cyc >= q[0].cyc + 2) begin
        check($sformatf("out_valid_w%0d", WS[d]), 32'(o_v[d]), 1);
        check($sformatf("out_res_w%0d", WS[d]), 32'(o_r[d]), 32'(q[0].res[d]));
        check($sformatf("out_match_w%0d", WS[d]), 32'(o_m[d]), 32'(q[0].m[d]));
      end else check($sformatf("out_valid_w%0d", WS[d]), 32'(o_v[d]), 0);
      check($sformatf("pass_cnt_w%0d", WS[d]), pcnt[d], 32'(pc[d]));
      check($sformatf("fail_cnt_w%0d", WS[d]), fcnt[d], 32'(fc[d]));
      check($sformatf("err_w%0d", WS[d]), 32'(o_e[d]), 32'(er[d]));
    end
    acc = iv && (q.size() < 2 || ir);
    if (irst) begin
      q.delete();
      pc = '{0, 0, 0};
      fc = '{0, 0, 0};
      er = '0;
    end else begin
      if (q.size() > 0 && cyc >= q[0].cyc + 2 && ir) begin
        e = q.pop_front();
        for (int d = 0; d < 3; d++) begin
          if (e.m[d]) pc[d] = (pc[d] + 1 > (1 << CS[d]) - 1) ? pc[d] : pc[d] + 1;
          else fc[d] = (fc[d] + 1 > (1 << CS[d]) - 1) ? fc[d] : fc[d] + 1;
          if (!e.m[d]) er[d] = 1'b1;
        end
      end
      if (ic) begin
        pc = '{0, 0, 0};
        fc = '{0, 0, 0};
        er = '0;
      end
      if (acc) begin
        e.cyc = cyc;
        e.res = rr;
        e.m = ~(rr ^ ex);
        q.push_back(e);
      end
    end
    cyc++;
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 4'd0, 1'b1, 1'b0, 1'b0, 1'b0);
  endtask

  logic [3:0] sa[6] = '{4'd1, 4'd7, 4'd8, 4'd12, 4'd0, 4'd15};
  int k;
  logic acc;

  initial begin
    pc = '{0, 0, 0};
    fc = '{0, 0, 0};
    er = '0;
    @(negedge clk);
    for (int i = 0; i < 3; i++) step(1'b0, 4'd0, 1'b1, 1'b0, 1'b0, 1'b1);
    for (int d = 0; d < 3; d++) begin
      check($sformatf("rst_out_res_w%0d", WS[d]), 32'(o_r[d]), 0);
      check($sformatf("rst_out_match_w%0d", WS[d]), 32'(o_m[d]), 0);
    end
    step(1'b1, 4'b1110, 1'b1, 1'b0, 1'b0, 1'b0);
    step(1'b0, 4'd0, 1'b1, 1'b0, 1'b0, 1'b0);
    check("single_out_valid_w2", 32'(o_v[1]), 1);
    check("single_out_res_w2", 32'(o_r[1]), 1);
    idle(2);
    check("single_pass_w2", pcnt[1], 1);
    step(1'b0, 4'd0, 1'b1, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 16; i++) step(1'b1, 4'(i), 1'b1, 1'b0, 1'b0, 1'b0);
    idle(3);
    check("sweep_pass_w4", pcnt[2], 16);
    check("sweep_err_w4", 32'(o_e[2]), 0);
    check("sweep_fail_w1", fcnt[0], 0);
    step(1'b1, 4'd3, 1'b1, 1'b0, 1'b1, 1'b0);
    step(1'b0, 4'd0, 1'b1, 1'b0, 1'b0, 1'b0);
    check("wrong_match_w4", 32'(o_m[2]), 0);
    idle(1);
    check("wrong_fail_w4", fcnt[2], 1);
    check("wrong_err_w4", 32'(o_e[2]), 1);
    step(1'b1, 4'd5, 1'b1, 1'b0, 1'b0, 1'b0);
    idle(3);
    check("err_sticky_w4", 32'(o_e[2]), 1);
    step(1'b0, 4'd0, 1'b1, 1'b1, 1'b0, 1'b0);
    check("clr_err_w4", 32'(o_e[2]), 0);
    check("clr_pass_w4", pcnt[2], 0);
    check("clr_fail_w4", fcnt[2], 0);
    k = 0;
    for (int c = 0; c < 16; c++) begin
      acc = (k < 6) && (q.size() < 2 || !(c >= 2 && c < 7));
      step(k < 6, k < 6 ? sa[k] : 4'd0, !(c >= 2 && c < 7), 1'b0, 1'b0, 1'b0);
      if (acc) k++;
    end
    check("stall_pass_w4", pcnt[2], 6);
    check("stall_sent", 32'(k), 6);
    step(1'b1, 4'd2, 1'b1, 1'b0, 1'b0, 1'b0);
    step(1'b1, 4'd9, 1'b1, 1'b0, 1'b0, 1'b0);
    step(1'b0, 4'd0, 1'b1, 1'b0, 1'b0, 1'b1);
    check("midrst_out_valid_w4", 32'(o_v[2]), 0);
    check("midrst_pass_w4", pcnt[2], 0);
    idle(3);
    for (int i = 0; i < 600; i++)
      step($urandom_range(3) != 0, 4'($urandom), $urandom_range(2) != 0, $urandom_range(49) == 0, $urandom_range(7) == 0, 1'b0);
    idle(4);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
